// File: rtl/lsu_ctrl.sv
// Load/store control unit between execute and DMEM: issues aligned requests as one
// native access, splits misaligned half/word requests into byte accesses.
module lsu_ctrl #(
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [13:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        dm_rden_o,
  output logic        dm_wen_o,
  output logic [1:0]  dm_byte_sel_o,
  output logic        dm_sign_o,
  output logic [13:0] dm_addr_o,
  output logic [31:0] dm_din_o,
  input  logic [31:0] dm_dout_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic        hold_q;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [13:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        split_q, split_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        req_illegal, req_mis;
  logic [1:0]  last_k;
  logic [7:0]  byte_k;
  logic        ready, rsp_v, rden, wen, sign;
  logic [1:0]  bsel;
  logic [13:0] daddr;
  logic [31:0] din;

  function automatic logic [31:0] load_ext(input logic is_word, input logic zext,
                                           input logic [31:0] w);
    if (is_word)   return w;
    else if (zext) return {16'h0000, w[15:0]};
    else           return {{16{w[15]}}, w[15:0]};
  endfunction

  // Loads reject 011/110/111; stores accept only 000/001/010.
  assign req_illegal = req_we_i ? (req_funct3_i[2] | (req_funct3_i[1:0] == 2'b11))
                                : ((req_funct3_i[1:0] == 2'b11) | (req_funct3_i == 3'b110));
  assign req_mis = ((req_funct3_i[1:0] == 2'b01) & req_addr_i[0]) |
                   ((req_funct3_i[1:0] == 2'b10) & (|req_addr_i[1:0]));
  assign last_k  = f3_q[1] ? 2'd3 : 2'd1;
  assign byte_k  = wdata_q[{k_q, 3'b000} +: 8];

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    split_d = split_q;
    k_d     = k_q;
    asm_d   = asm_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    ready   = 1'b0;
    rsp_v   = 1'b0;
    rden    = 1'b0;
    wen     = 1'b0;
    bsel    = 2'b00;
    sign    = 1'b0;
    daddr   = 14'd0;
    din     = 32'd0;
    case (state_q)
      IDLE: begin
        ready = ~hold_q;
        if (req_valid_i && !hold_q) begin
          we_d    = req_we_i;
          f3_d    = req_funct3_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          split_d = req_mis;
          k_d     = 2'd0;
          asm_d   = 32'd0;
          err_d   = req_illegal | (req_mis & ~MISALIGN_EN);
          if (err_d) begin
            rdata_d = 32'd0;
            state_d = RESP;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        rden = ~we_q;
        wen  = we_q;
        if (split_q) begin
          daddr = addr_q + {12'd0, k_q};
          sign  = 1'b1;
          din   = {24'd0, byte_k};
        end else begin
          daddr = addr_q;
          bsel  = f3_q[1:0];
          sign  = f3_q[2];
          din   = wdata_q;
        end
        if (!we_q) begin
          state_d = WAIT;
        end else if (split_q && (k_q != last_k)) begin
          k_d = k_q + 2'd1;
        end else begin
          rdata_d = 32'd0;
          state_d = RESP;
        end
      end
      WAIT: begin
        asm_d[{k_q, 3'b000} +: 8] = dm_dout_i[7:0];
        k_d = k_q + 2'd1;
        if (!split_q) begin
          rdata_d = dm_dout_i;
          state_d = RESP;
        end else if (k_q == last_k) begin
          rdata_d = load_ext(f3_q[1], f3_q[2], asm_d);
          state_d = RESP;
        end else begin
          state_d = ACCESS;
        end
      end
      RESP: begin
        rsp_v   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset forces every output low immediately so an in-flight split store stops writing.
  assign req_ready_o   = ready & ~rst_i;
  assign rsp_valid_o   = rsp_v & ~rst_i;
  assign rsp_err_o     = rsp_v & err_q & ~rst_i;
  assign rsp_rdata_o   = rst_i ? 32'd0 : rdata_q;
  assign dm_rden_o     = rden & ~rst_i;
  assign dm_wen_o      = wen & ~rst_i;
  assign dm_byte_sel_o = rst_i ? 2'b00 : bsel;
  assign dm_sign_o     = sign & ~rst_i;
  assign dm_addr_o     = rst_i ? 14'd0 : daddr;
  assign dm_din_o      = rst_i ? 32'd0 : din;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      hold_q  <= 1'b1;
      k_q     <= 2'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      hold_q  <= 1'b0;
      k_q     <= k_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    we_q    <= we_d;
    f3_q    <= f3_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    split_q <= split_d;
    asm_q   <= asm_d;
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: byte-array reference model feeds a scoreboard checked by a
// monitor; a second instance has misaligned splitting disabled.
`timescale 1ns/1ps
module tb_lsu_ctrl;
  localparam int MEM_SZ = 16384;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_f3 = 3'd0;
  logic [13:0] req_addr = 14'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready, rsp_valid, rsp_err, dm_rden, dm_wen, dm_sign;
  logic [31:0] rsp_rdata, dm_din, dm_dout;
  logic [1:0]  dm_bsel;
  logic [13:0] dm_addr;

  lsu_ctrl #(.MISALIGN_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_funct3_i(req_f3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .dm_rden_o(dm_rden), .dm_wen_o(dm_wen), .dm_byte_sel_o(dm_bsel), .dm_sign_o(dm_sign),
    .dm_addr_o(dm_addr), .dm_din_o(dm_din), .dm_dout_i(dm_dout)
  );

  logic        r0_valid = 1'b0, r0_we = 1'b0;
  logic [2:0]  r0_f3 = 3'd0;
  logic [13:0] r0_addr = 14'd0;
  logic [31:0] r0_wdata = 32'd0;
  logic        r0_ready, r0_rsp_valid, r0_rsp_err, r0_rden, r0_wen, r0_sign;
  logic [31:0] r0_rdata, r0_din, r0_dout;
  logic [1:0]  r0_bsel;
  logic [13:0] r0_addr_o;
  assign r0_dout = 32'd0;

  lsu_ctrl #(.MISALIGN_EN(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(r0_valid), .req_ready_o(r0_ready),
    .req_we_i(r0_we), .req_funct3_i(r0_f3), .req_addr_i(r0_addr), .req_wdata_i(r0_wdata),
    .rsp_valid_o(r0_rsp_valid), .rsp_rdata_o(r0_rdata), .rsp_err_o(r0_rsp_err),
    .dm_rden_o(r0_rden), .dm_wen_o(r0_wen), .dm_byte_sel_o(r0_bsel), .dm_sign_o(r0_sign),
    .dm_addr_o(r0_addr_o), .dm_din_o(r0_din), .dm_dout_i(r0_dout)
  );

  // DMEM behavioural model: native byte/half/word access, read data one cycle later.
  logic [7:0]  mem     [MEM_SZ];
  logic [7:0]  ref_mem [MEM_SZ];
  logic        mem_load = 1'b1;
  logic [13:0] a1, a2, a3;
  assign a1 = dm_addr + 14'd1;
  assign a2 = dm_addr + 14'd2;
  assign a3 = dm_addr + 14'd3;

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + 11) ^ (i >> 7));
  endfunction

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < MEM_SZ; i++) mem[i] <= pat(i);
    end else if (dm_wen) begin
      mem[dm_addr] <= dm_din[7:0];
      if (dm_bsel != 2'b00) mem[a1] <= dm_din[15:8];
      if (dm_bsel == 2'b10) begin
        mem[a2] <= dm_din[23:16];
        mem[a3] <= dm_din[31:24];
      end
    end
    if (dm_rden) begin
      case (dm_bsel)
        2'b00:   dm_dout <= {{24{~dm_sign & mem[dm_addr][7]}}, mem[dm_addr]};
        2'b01:   dm_dout <= {{16{~dm_sign & mem[a1][7]}}, mem[a1], mem[dm_addr]};
        default: dm_dout <= {mem[a3], mem[a2], mem[a1], mem[dm_addr]};
      endcase
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nacc;
    int          t0;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int failures = 0;
  int scnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Reference: request semantics from width/sign rules over a flat byte array.
  task automatic model(input logic we, input logic [2:0] f3, input logic [13:0] a,
                       input logic [31:0] wd, output exp_t e);
    int size;
    bit legal, mis;
    logic [31:0] v;
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis   = legal && ((int'(a) % size) != 0);
    e.rdata = 32'd0;
    e.err   = 1'b0;
    if (!legal) begin
      e.err = 1'b1; e.lat = 1; e.nacc = 0;
    end else if (we) begin
      for (int i = 0; i < size; i++) ref_mem[(int'(a) + i) % MEM_SZ] = wd[8*i +: 8];
      e.lat  = mis ? size + 1 : 2;
      e.nacc = mis ? size : 1;
    end else begin
      v = 32'd0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[(int'(a) + i) % MEM_SZ];
      if (size < 4 && !f3[2] && v[8*size-1]) begin
        for (int i = 8*size; i < 32; i++) v[i] = 1'b1;
      end
      e.rdata = v;
      e.lat   = mis ? 2*size + 1 : 3;
      e.nacc  = mis ? size : 1;
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [13:0] a,
                       input logic [31:0] wd, input logic use_x, input logic [31:0] xr);
    exp_t e;
    int w = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_f3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clk);
    while (!req_ready && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'(req_ready), 32'd1);
    end else begin
      model(we, f3, a, wd, e);
      if (use_x) e.rdata = xr;
      e.t0 = cyc;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    @(negedge clk);
    while (!(req_ready && sbq.size() == 0) && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("idle_timeout", 32'(req_ready && sbq.size() == 0), 32'd1);
  endtask

  task automatic run0(input logic we, input logic [2:0] f3, input logic [13:0] a,
                      input logic exp_err, input int exp_lat, input int exp_acc);
    int t = 0;
    int nacc = 0;
    bit got = 1'b0;
    logic err_s = 1'b0;
    logic [31:0] rd_s = 32'd0;
    @(posedge clk); #1;
    r0_valid = 1'b1; r0_we = we; r0_f3 = f3; r0_addr = a; r0_wdata = 32'h5A5A0FF0;
    @(negedge clk);
    check("m0_ready", 32'(r0_ready), 32'd1);
    @(posedge clk); #1;
    r0_valid = 1'b0;
    while (!got && t < 20) begin
      @(negedge clk);
      t++;
      if (r0_rden || r0_wen) nacc++;
      if (r0_rsp_valid) begin
        got = 1'b1; err_s = r0_rsp_err; rd_s = r0_rdata;
      end
    end
    check("m0_latency", got ? 32'(t) : 32'hFFFFFFFF, 32'(exp_lat));
    check("m0_err", 32'(err_s), 32'(exp_err));
    check("m0_rdata", rd_s, 32'd0);
    check("m0_accesses", 32'(nacc), 32'(exp_acc));
    @(negedge clk);
    check("m0_idle_dm", {13'd0, r0_bsel, r0_sign, r0_addr_o} | r0_din, 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (dm_rden || dm_wen) scnt++;
    check("dm_strobe_excl", 32'(dm_rden & dm_wen), 32'd0);
    if (req_ready)
      check("dm_idle_zero", 32'((dm_din != 0) || (dm_addr != 0) || (dm_bsel != 0) ||
                                dm_sign || dm_rden || dm_wen), 32'd0);
    if (req_valid && req_ready) scnt = 0;
    if (rsp_valid) begin
      if (sbq.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        check("rsp_latency", 32'(cyc - e.t0), 32'(e.lat));
        check("dm_accesses", 32'(scnt), 32'(e.nacc));
      end
    end
  end

  initial begin
    logic [7:0] b4;
    logic [7:0] pre2, pre3, pre4;
    int nbad;
    for (int i = 0; i < MEM_SZ; i++) ref_mem[i] = pat(i);
    @(posedge clk); #1;
    mem_load = 1'b0;
    @(negedge clk);
    check("reset_ctl", {24'd0, req_ready, rsp_valid, rsp_err, dm_rden, dm_wen, dm_bsel, dm_sign}, 32'd0);
    check("reset_rdata", rsp_rdata, 32'd0);
    check("reset_dm_addr", 32'(dm_addr), 32'd0);
    check("reset_dm_din", dm_din, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_ready_low", 32'(req_ready), 32'd0);
    check("post_reset_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    check("post_reset_ready_high", 32'(req_ready), 32'd1);

    issue(1'b1, 3'b010, 14'h0000, 32'hDEADBEEF, 1'b1, 32'h0);
    issue(1'b0, 3'b010, 14'h0000, 32'h0, 1'b1, 32'hDEADBEEF);
    issue(1'b0, 3'b000, 14'h0003, 32'h0, 1'b1, 32'hFFFFFFDE);
    issue(1'b0, 3'b100, 14'h0003, 32'h0, 1'b1, 32'h000000DE);
    issue(1'b0, 3'b101, 14'h0002, 32'h0, 1'b1, 32'h0000DEAD);
    issue(1'b0, 3'b001, 14'h0000, 32'h0, 1'b1, 32'hFFFFBEEF);
    issue(1'b1, 3'b010, 14'h0005, 32'h11223344, 1'b1, 32'h0);
    issue(1'b0, 3'b010, 14'h0005, 32'h0, 1'b1, 32'h11223344);
    b4 = ref_mem[4];
    issue(1'b0, 3'b010, 14'h0004, 32'h0, 1'b1, {24'h223344, b4});
    issue(1'b1, 3'b001, 14'h3FFF, 32'h0000A5C3, 1'b1, 32'h0);
    issue(1'b0, 3'b001, 14'h3FFF, 32'h0, 1'b1, 32'hFFFFA5C3);
    issue(1'b0, 3'b011, 14'h0008, 32'h0, 1'b1, 32'h0);
    issue(1'b1, 3'b100, 14'h0008, 32'h12345678, 1'b1, 32'h0);
    wait_idle();

    // Reset during the second byte of a split store
    pre2 = ref_mem[2]; pre3 = ref_mem[3]; pre4 = ref_mem[4];
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_f3 = 3'b010; req_addr = 14'h0001; req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    check("rst_test_accept", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_strobes", {30'd0, dm_rden, dm_wen}, 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_hold_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("rst_mid_ready_back", 32'(req_ready), 32'd1);
    check("rst_mid_byte0", 32'(mem[1]), 32'h0D);
    check("rst_mid_byte1", 32'(mem[2]), 32'(pre2));
    check("rst_mid_byte2", 32'(mem[3]), 32'(pre3));
    check("rst_mid_byte3", 32'(mem[4]), 32'(pre4));
    ref_mem[1] = 8'h0D;

    run0(1'b0, 3'b010, 14'h0002, 1'b1, 1, 0);
    run0(1'b1, 3'b001, 14'h0001, 1'b1, 1, 0);
    run0(1'b0, 3'b101, 14'h0003, 1'b1, 1, 0);
    run0(1'b1, 3'b010, 14'h0004, 1'b0, 2, 1);
    run0(1'b0, 3'b001, 14'h0002, 1'b0, 3, 1);
    run0(1'b0, 3'b000, 14'h0001, 1'b0, 3, 1);

    for (int n = 0; n < 300; n++) begin
      logic        we;
      logic [2:0]  f3;
      logic [13:0] a;
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        f3[1:0] = 2'($urandom_range(0, 2));
        f3[2]   = ~we & 1'($urandom_range(0, 1));
      end
      a = ($urandom_range(0, 1) == 1) ? 14'($urandom_range(0, 31))
                                      : 14'(14'h3FF0 + 14'($urandom_range(0, 15)));
      issue(we, f3, a, $urandom, 1'b0, 32'h0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    wait_idle();
    repeat (5) @(posedge clk);
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    nbad = 0;
    for (int i = 0; i < MEM_SZ; i++) if (mem[i] !== ref_mem[i]) nbad++;
    check("mem_final", 32'(nbad), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store control unit between the execute stage and DMEM. It accepts one memory request at a time from the pipeline and decodes the RISC-V funct3 width and sign. Aligned accesses are issued to DMEM as a single native access. Misaligned half/word accesses are split into sequential byte accesses, and load bytes are reassembled and extended before a one-cycle response.

## Interface
- MISALIGN_EN, default 1: 1 = split misaligned accesses into bytes; 0 = misaligned request returns error, no DMEM access.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset; synchronous, active-high.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  unit idle, request accepted when VALID&READY at edge.
- REQ_WE  in  1  1 = store, 0 = load.
- REQ_FUNCT3  in  3  load: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; store: 000 sb, 001 sh, 010 sw.
- REQ_ADDR  in  14  byte address.
- REQ_WDATA  in  32  store data, little-endian.
- RSP_VALID  out  1  one-cycle completion pulse.
- RSP_RDATA  out  32  extended load data (0 for stores/errors); held until next RSP_VALID.
- RSP_ERR  out  1  illegal funct3 or misaligned with MISALIGN_EN=0; valid with RSP_VALID.
- DM_RDEN, DM_WEN  out  1 each  DMEM strobes, one cycle per access.
- DM_BYTE_SEL  out  2  00 byte, 01 half, 10 word.
- DM_SIGN  out  1  0 = sign-extend, 1 = zero-extend (DMEM convention).
- DM_ADDR  out  14  DMEM byte address.
- DM_DIN  out  32  DMEM write data.
- DM_DOUT  in  32  DMEM read data, valid the cycle after DM_RDEN.

## Operation
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE: REQ_READY=1. On accept, latch WE, funct3, addr, wdata; clear byte index k and assembly register. Next state is RESP with ERR if the request is illegal, otherwise ACCESS.
- Illegal: load funct3 011/110/111; store funct3 other than 000/001/010; misaligned with MISALIGN_EN=0.
- Misaligned: half with addr[0]=1; word with addr[1:0]≠00. Byte count N=2 (half) or 4 (word).
- Aligned ACCESS: single DMEM access.
  - BYTE_SEL from funct3[1:0]; DM_SIGN=funct3[2]; DM_DIN=wdata.
  - Store goes to RESP.
  - Load goes to WAIT, captures DM_DOUT into RSP_RDATA, then goes to RESP.
- Misaligned ACCESS k (k=0..N-1):
  - DM_ADDR = addr+k mod 2^14, wrapping 0x3FFF→0x0000.
  - BYTE_SEL=00; DM_SIGN=1.
  - Store: DM_DIN[7:0]=wdata[8k+7:8k], upper DIN bits 0; k++; after byte N-1 go to RESP.
  - Load: go to WAIT, capture DM_DOUT[7:0] into assembly byte k, k++; go back to ACCESS or, after the last byte, to RESP.
  - Final extension: sign-extend from bit 15 for lh; no extension for lw; zero-extend for lhu.
- RESP: RSP_VALID=1 for exactly one cycle, then IDLE. No response backpressure.
- DM strobes are 0 outside ACCESS. DM_RDEN and DM_WEN are never both 1.
- DM_ADDR, DM_DIN, DM_BYTE_SEL and DM_SIGN are 0 when idle.

## Timing
- Accept at edge 0.
- Aligned store: DM_WEN in cycle 1; RSP_VALID in cycle 2.
- Aligned load: DM_RDEN in cycle 1; DATA captured in cycle 2; RSP_VALID in cycle 3.
- Misaligned half: load RSP_VALID at cycle 5; store at cycle 3.
- Misaligned word: load RSP_VALID at cycle 9; store at cycle 5.
- Error: RSP_VALID at cycle 1, no DM strobes.
- REQ_READY is 0 from accept until the cycle after RSP_VALID; back-to-back accept is possible on the IDLE cycle after RESP.
- Reset: while RST=1 and one cycle after, all outputs are 0, including REQ_READY, RSP_RDATA and RSP_ERR. The state is IDLE on the first clock after RST deasserts.
- Reset mid-operation: strobes drop at the next edge and no RSP_VALID is issued. Bytes of a split store that were already written remain in memory.

## Test plan
- sw 0xDEADBEEF @0x0000 then lw @0x0000 -> DM_WEN cycle1/RSP cycle2; load RSP_RDATA=0xDEADBEEF at cycle 3, ERR=0.
- After the above: lb @0x0003 -> 0xFFFFFFDE; lbu @0x0003 -> 0x000000DE; lhu @0x0002 -> 0x0000DEAD; lh @0x0000 -> 0xFFFFBEEF.
- sw 0x11223344 @0x0005 -> four byte writes to 5,6,7,8 at cycles 1-4, RSP at 5; lw @0x0005 -> 0x11223344 with RSP at cycle 9; lw @0x0004 -> 0x223344xx, where xx is the prior byte.
- sh 0xA5C3 @0x3FFF -> byte writes at 0x3FFF then 0x0000; lh @0x3FFF -> 0xFFFFA5C3.
- Load funct3=011 and MISALIGN_EN=0 with lw @0x0002 -> RSP_VALID cycle 1, ERR=1, RDATA=0, no DM strobes.
- RST pulse during cycle 2 of misaligned sw @0x0001 -> no RSP_VALID; the first byte is written and the rest untouched; REQ_READY=1 one cycle after RST falls.
